// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter/rotator: shifts up to STEP bits per RUN cycle
// and registers the result on entry to DONE, holding it otherwise.
module shift_sequencer #(
    parameter int unsigned STEP = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] in,
    input  logic [31:0] shift,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_SHL  = 3'd0,
        OP_SHR  = 3'd1,
        OP_SHRA = 3'd2,
        OP_ROL  = 3'd3,
        OP_ROR  = 3'd4
    } op_e;

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] work_q, work_d;
    logic [5:0]  rem_q, rem_d;
    logic [31:0] out_q, out_d;

    logic [5:0]  amt;
    logic [5:0]  chunk;
    logic [31:0] stepped;

    // Linear shifts saturate at 32; rotates wrap modulo 32; PASS never runs.
    always_comb begin
        amt = '0;
        case (op)
            OP_SHL, OP_SHR, OP_SHRA: amt = (|shift[31:5]) ? 6'd32 : {1'b0, shift[4:0]};
            OP_ROL, OP_ROR:          amt = {1'b0, shift[4:0]};
            default:                 amt = '0;
        endcase
    end

    // One RUN step; chunk is never zero while in RUN, so the rotate is safe.
    always_comb begin
        chunk   = (rem_q < STEP_W) ? rem_q : STEP_W;
        stepped = work_q;
        case (op_q)
            OP_SHL:  stepped = work_q << chunk;
            OP_SHR:  stepped = work_q >> chunk;
            OP_SHRA: stepped = 32'($signed(work_q) >>> chunk);
            OP_ROL:  stepped = (work_q << chunk) | (work_q >> (6'd32 - chunk));
            OP_ROR:  stepped = (work_q >> chunk) | (work_q << (6'd32 - chunk));
            default: stepped = work_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            op_q    <= '0;
            work_q  <= '0;
            rem_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        rem_d   = rem_q;
        out_d   = out_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    op_d   = op;
                    work_d = in;
                    rem_d  = amt;
                    if (amt == '0) begin
                        state_d = DONE;
                        out_d   = in;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                work_d = stepped;
                rem_d  = rem_q - chunk;
                if (rem_q <= STEP_W) begin
                    state_d = DONE;
                    out_d   = stepped;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    assign out = out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: three instances (STEP 8, 1, 16) share stimulus and
// are checked every cycle against a transaction-level model, plus literal checks.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        clr, start;
    logic [2:0]  op;
    logic [31:0] in_v, shift_v;

    logic        busy8, done8, busy1, done1, busy16, done16;
    logic [31:0] out8, out1, out16;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    shift_sequencer #(.STEP(8)) u_s8 (
        .clk(clk), .clr(clr), .start(start), .op(op), .in(in_v), .shift(shift_v),
        .busy(busy8), .done(done8), .out(out8)
    );
    shift_sequencer #(.STEP(1)) u_s1 (
        .clk(clk), .clr(clr), .start(start), .op(op), .in(in_v), .shift(shift_v),
        .busy(busy1), .done(done1), .out(out1)
    );
    shift_sequencer #(.STEP(16)) u_s16 (
        .clk(clk), .clr(clr), .start(start), .op(op), .in(in_v), .shift(shift_v),
        .busy(busy16), .done(done16), .out(out16)
    );

    logic        dut_busy [3];
    logic        dut_done [3];
    logic [31:0] dut_out  [3];
    assign dut_busy[0] = busy8;  assign dut_done[0] = done8;  assign dut_out[0] = out8;
    assign dut_busy[1] = busy1;  assign dut_done[1] = done1;  assign dut_out[1] = out1;
    assign dut_busy[2] = busy16; assign dut_done[2] = done16; assign dut_out[2] = out16;

    // ---------------- reference model ----------------
    int unsigned step_c [3] = '{8, 1, 16};
    logic        m_busy [3];
    logic        m_done [3];
    logic [31:0] m_out  [3];
    logic [31:0] m_pend [3];
    int unsigned m_cnt  [3];

    function automatic logic [31:0] ref_result(logic [2:0] o, logic [31:0] a, logic [31:0] s);
        int unsigned r;
        r = s % 32;
        case (o)
            3'd0: return a << s;
            3'd1: return a >> s;
            3'd2: return $signed(a) >>> s;
            3'd3: return (a << r) | (a >> (32 - r));
            3'd4: return (a >> r) | (a << (32 - r));
            default: return a;
        endcase
    endfunction

    function automatic int unsigned ref_amt(logic [2:0] o, logic [31:0] s);
        case (o)
            3'd0, 3'd1, 3'd2: return (s > 31) ? 32 : s;
            3'd3, 3'd4:       return s % 32;
            default:          return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (clr) begin
                m_busy[k] = 1'b0; m_done[k] = 1'b0; m_out[k] = '0; m_cnt[k] = 0;
            end else if (!m_busy[k] && start) begin
                int unsigned n;
                n = (ref_amt(op, shift_v) + step_c[k] - 1) / step_c[k];
                if (n == 0) begin
                    m_done[k] = 1'b1;
                    m_out[k]  = ref_result(op, in_v, shift_v);
                end else begin
                    m_busy[k] = 1'b1;
                    m_done[k] = 1'b0;
                    m_cnt[k]  = n;
                    m_pend[k] = ref_result(op, in_v, shift_v);
                end
            end else if (m_busy[k]) begin
                m_cnt[k] = m_cnt[k] - 1;
                if (m_cnt[k] == 0) begin
                    m_busy[k] = 1'b0;
                    m_done[k] = 1'b1;
                    m_out[k]  = m_pend[k];
                end
            end else begin
                m_done[k] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dut_busy[k] !== m_busy[k] || dut_done[k] !== m_done[k] || dut_out[k] !== m_out[k]) begin
                    errors++;
                    $display("FAIL model_cmp STEP=%0d t=%0t: busy=%b done=%b out=%h, expected busy=%b done=%b out=%h",
                             step_c[k], $time, dut_busy[k], dut_done[k], dut_out[k], m_busy[k], m_done[k], m_out[k]);
                end
            end
        end
    end

    // ---------------- directed helpers (STEP=8 instance) ----------------
    task automatic chk8(input string name, input logic eb, input logic ed, input logic [31:0] eo);
        checks++;
        if (busy8 !== eb || done8 !== ed || out8 !== eo) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b out=%h, expected busy=%b done=%b out=%h",
                     name, busy8, done8, out8, eb, ed, eo);
        end
        checks++;
        if (m_busy[0] !== eb || m_done[0] !== ed || m_out[0] !== eo) begin
            errors++;
            $display("FAIL %s_model: busy=%b done=%b out=%h, expected busy=%b done=%b out=%h",
                     name, m_busy[0], m_done[0], m_out[0], eb, ed, eo);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] s);
        start   = 1'b1;
        op      = o;
        in_v    = a;
        shift_v = s;
        @(negedge clk);
        start   = 1'b0;
        op      = 3'($urandom);
        in_v    = $urandom;
        shift_v = $urandom;
    endtask

    task automatic expect_op(input string name, input int nb, input logic [31:0] eo, input logic [31:0] prev);
        for (int i = 0; i < nb; i++) begin
            chk8({name, "_busy"}, 1'b1, 1'b0, prev);
            @(negedge clk);
        end
        chk8({name, "_done"}, 1'b0, 1'b1, eo);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; op = '0; in_v = '0; shift_v = '0;
        repeat (2) @(negedge clk);
        clr    = 1'b0;
        chk_on = 1'b1;
        chk8("reset", 1'b0, 1'b0, 32'h0);

        @(negedge clk); issue(3'd0, 32'h0000_0001, 32'd5);
        expect_op("shl5", 1, 32'h0000_0020, 32'h0);
        @(negedge clk); issue(3'd2, 32'h8000_0000, 32'h40);
        expect_op("shra32", 4, 32'hFFFF_FFFF, 32'h0000_0020);
        @(negedge clk); issue(3'd1, 32'hF000_0000, 32'd20);
        expect_op("shr20", 3, 32'h0000_0F00, 32'hFFFF_FFFF);
        @(negedge clk); issue(3'd4, 32'h1234_5678, 32'd36);
        expect_op("ror36", 1, 32'h8123_4567, 32'h0000_0F00);
        issue(3'd0, 32'h0000_0003, 32'd1);
        expect_op("b2b_shl", 1, 32'h0000_0006, 32'h8123_4567);

        @(negedge clk); issue(3'd3, 32'hA5A5_0F0F, 32'd0);
        expect_op("rol0", 0, 32'hA5A5_0F0F, 32'h0);
        issue(3'd5, 32'hDEAD_BEEF, 32'd7);
        expect_op("pass_b2b", 0, 32'hDEAD_BEEF, 32'h0);
        @(negedge clk); chk8("pass_idle", 1'b0, 1'b0, 32'hDEAD_BEEF);

        @(negedge clk); issue(3'd0, 32'h0000_0001, 32'd31);
        chk8("ign_b1", 1'b1, 1'b0, 32'hDEAD_BEEF);
        start = 1'b1; op = 3'd5; in_v = 32'h5555_5555; shift_v = '0;
        @(negedge clk); start = 1'b0;
        chk8("ign_b2", 1'b1, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk); chk8("ign_b3", 1'b1, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk); chk8("ign_b4", 1'b1, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk); chk8("ign_done", 1'b0, 1'b1, 32'h8000_0000);

        @(negedge clk); issue(3'd2, 32'h8000_0000, 32'd40);
        chk8("abort_run", 1'b1, 1'b0, 32'h8000_0000);
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk8("abort", 1'b0, 1'b0, 32'h0);
        repeat (6) begin
            @(negedge clk); chk8("no_done", 1'b0, 1'b0, 32'h0);
        end

        repeat (1500) begin
            @(negedge clk);
            clr   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom_range(0, 7));
            in_v  = $urandom;
            case ($urandom_range(0, 3))
                0:       shift_v = 32'($urandom_range(0, 33));
                1:       shift_v = $urandom;
                2:       shift_v = (32'($urandom_range(0, 3)) << 5) | 32'($urandom_range(0, 31));
                default: shift_v = '0;
            endcase
        end
        @(negedge clk);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter STEP, default 8, giving the maximum bits shifted per RUN cycle; legal values are 1, 2, 4, 8, 16.
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have input clr, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have input start, 1 bit, an operation request.
REQ-005 The block SHALL have input op, 3 bits, the opcode: 000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, 101-111 PASS.
REQ-006 The block SHALL have input in, 32 bits, the operand.
REQ-007 The block SHALL have input shift, 32 bits, the unsigned shift amount.
REQ-008 The block SHALL have output busy, 1 bit, high while an operation is in progress.
REQ-009 The block SHALL have output done, 1 bit, a one-cycle pulse when the result is valid.
REQ-010 The block SHALL have output out, 32 bits, the registered result.

Function
REQ-011 The block SHALL implement states IDLE, RUN and DONE; busy=1 only in RUN, and done=1 only in DONE.
REQ-012 Acceptance: start=1 in IDLE or DONE SHALL latch op, in, shift and the effective amount amt; start in RUN SHALL be ignored.
REQ-013 amt for SHL, SHR and SHRA SHALL be 32 if any of shift[31:5] is set, else shift[4:0].
REQ-014 amt for ROL and ROR SHALL be shift[4:0] (mod 32).
REQ-015 amt for PASS SHALL be 0.
REQ-016 On acceptance, next state SHALL be DONE if amt=0, else RUN.
REQ-017 Each RUN cycle SHALL apply min(remaining, STEP) bits of the latched operation to the working register and decrement remaining by that amount; when remaining reaches 0, next state SHALL be DONE.
REQ-018 Latency: for acceptance at edge T, done SHALL be high during cycle T+1+N, where N=ceil(amt/STEP), and busy SHALL be high during cycles T+1..T+N.
REQ-019 Results: SHL and SHR SHALL zero-fill; SHRA SHALL fill with the latched in[31]; ROL and ROR SHALL rotate; amt=32 SHALL give 0 for SHL and SHR and 32 copies of in[31] for SHRA; PASS SHALL give out=in.
REQ-020 out SHALL update only on the transition into DONE and SHALL hold its value in all other cycles, including through the next RUN.
REQ-021 DONE SHALL last one cycle; without start, next state SHALL be IDLE.
REQ-022 start in DONE SHALL be accepted (back-to-back operation); done SHALL drop the following cycle unless the new amt=0, in which case done SHALL stay high for one more cycle with the new result.
REQ-023 Inputs other than start SHALL be don't-care except on the cycle of acceptance.

Reset
REQ-024 clr=1 at a rising edge SHALL force state=IDLE, busy=0, done=0, out=0x00000000 and remaining=0, regardless of state.
REQ-025 clr SHALL take priority over start.
REQ-026 clr during RUN SHALL abort the operation with no done pulse.

Verification
REQ-027 The bench SHALL cover: SHL, in=0x00000001, shift=5, STEP=8 -> busy during T+1, done at T+2, out=0x00000020.
REQ-028 The bench SHALL cover: SHRA, in=0x80000000, shift=0x40 -> amt=32, busy during T+1..T+4, done at T+5, out=0xFFFFFFFF.
REQ-029 The bench SHALL cover: SHR, in=0xF0000000, shift=20 -> done at T+4, out=0x00000F00; ROR, in=0x12345678, shift=36 -> done at T+2, out=0x81234567.
REQ-030 The bench SHALL cover: ROL with shift=0, and PASS, in=0xDEADBEEF -> busy never high, done at T+1, out=in.
REQ-031 The bench SHALL cover: start pulsed during RUN -> ignored, original result delivered; then clr during RUN -> next cycle busy=0, done=0, out=0, and no done thereafter.
REQ-032 The bench SHALL cover: new start on the DONE cycle (SHL, in=0x3, shift=1, follows ROR above) -> done at the next T+2, out=0x00000006, previous result held during RUN.
REQ-033 The bench SHALL also cover randomized operations against a Verilog operator reference, with STEP set to 1 and to 16.
